// File: rtl/mem_master_if.sv
// mem_master_if: request/response port plus memory pin bundle for mem_master.
// master modport is the controller view; slave modport is the agent/memory view.
interface mem_master_if #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 8
);
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic [ADDR_W-1:0] req_len;
   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_rdata;
   logic              wr_done;
   logic              busy;
   logic              mem_read;
   logic              mem_write;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport master (
      input  req_valid, req_we, req_addr, req_wdata, req_len, mem_rdata,
      output req_ready, rsp_valid, rsp_rdata, wr_done, busy,
             mem_read, mem_write, mem_addr, mem_wdata
   );

   modport slave (
      output req_valid, req_we, req_addr, req_wdata, req_len, mem_rdata,
      input  req_ready, rsp_valid, rsp_rdata, wr_done, busy,
             mem_read, mem_write, mem_addr, mem_wdata
   );
endinterface

// File: rtl/mem_master.sv
// mem_master: initiator for a synchronous 2**ADDR_W x DATA_W memory.
// Single-beat writes, incrementing (wrapping) read bursts, tagged read-data capture.
module mem_master #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 8,
   parameter int RD_LAT = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   mem_master_if.master bus
);
   typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

   localparam logic [RD_LAT-1:0] LAST_TAG = RD_LAT'(1) << (RD_LAT - 1);

   state_t            r_state, w_state_nx;
   logic [ADDR_W-1:0] r_cnt;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [DATA_W-1:0] r_rdata;
   logic              r_read;
   logic              r_write;
   logic              r_wr_done;
   logic [RD_LAT:0]   r_pipe;
   logic              w_accept;
   logic              w_step;
   logic              w_last;

   assign bus.req_ready = (r_state == IDLE) && rst_n;
   assign bus.busy      = r_state != IDLE;
   assign bus.mem_read  = r_read;
   assign bus.mem_write = r_write;
   assign bus.mem_addr  = r_addr;
   assign bus.mem_wdata = r_wdata;
   assign bus.rsp_valid = r_pipe[RD_LAT];
   assign bus.rsp_rdata = r_rdata;
   assign bus.wr_done   = r_wr_done;

   assign w_accept = bus.req_valid && bus.req_ready;
   assign w_step   = (r_state == READ) && (r_cnt != '0);
   // Last beat is being captured when only the oldest in-flight tag remains.
   assign w_last   = r_pipe[RD_LAT-1:0] == LAST_TAG;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nx;
   end

   always_comb begin
      w_state_nx = r_state;
      case (r_state)
         IDLE:    w_state_nx = w_accept ? (bus.req_we ? WRITE : READ) : IDLE;
         WRITE:   w_state_nx = IDLE;
         READ:    w_state_nx = (r_cnt == '0) ? DRAIN : READ;
         DRAIN:   w_state_nx = w_last ? IDLE : DRAIN;
         default: w_state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt     <= '0;
         r_addr    <= '0;
         r_wdata   <= '0;
         r_rdata   <= '0;
         r_read    <= 1'b0;
         r_write   <= 1'b0;
         r_wr_done <= 1'b0;
         r_pipe    <= '0;
      end else begin
         r_write   <= w_accept && bus.req_we;
         r_read    <= (w_accept && !bus.req_we) || w_step;
         r_wr_done <= r_state == WRITE;
         if (w_accept) begin
            r_addr <= bus.req_addr;
            r_cnt  <= bus.req_len;
            if (bus.req_we) r_wdata <= bus.req_wdata;
         end else if (w_step) begin
            r_addr <= r_addr + ADDR_W'(1);
            r_cnt  <= r_cnt - ADDR_W'(1);
         end
         r_pipe <= {r_pipe[RD_LAT-1:0], r_read};
         if (r_pipe[RD_LAT-1]) r_rdata <= bus.mem_rdata;
      end
   end
endmodule

// File: tb/tb_mem_master.sv
// tb_mem_master: directed table-driven bench for mem_master with a 32x8 latency-1 memory model.
module tb_mem_master;
   localparam int AW = 5;
   localparam int DW = 8;

   typedef struct {
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic [AW-1:0] len;
      logic [DW-1:0] exp0;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mem_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
   mem_master #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   logic [DW-1:0] ram    [32];
   logic [DW-1:0] shadow [32];

   always @(posedge clk) begin
      if (bus.mem_write && !bus.mem_read) ram[bus.mem_addr] <= bus.mem_wdata;
      if (bus.mem_read && !bus.mem_write) bus.mem_rdata <= ram[bus.mem_addr];
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;
   int overlaps = 0;
   logic [DW-1:0] q_data [$];
   int            q_cyc  [$];
   logic [AW-1:0] q_addr [$];

   always @(negedge clk) begin
      if (bus.rsp_valid) begin
         q_data.push_back(bus.rsp_rdata);
         q_cyc.push_back(cyc);
      end
      if (bus.mem_read) q_addr.push_back(bus.mem_addr);
      if (bus.mem_read && bus.mem_write) overlaps++;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic send(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [AW-1:0] len, output int c0);
      int n = 0;
      bus.req_we    = we;
      bus.req_addr  = a;
      bus.req_wdata = d;
      bus.req_len   = len;
      bus.req_valid = 1'b1;
      while (!bus.req_ready && n < 200) begin
         @(negedge clk);
         #1;
         n++;
      end
      check("accept_wait", (n < 200) ? 1 : 0, 1);
      c0 = cyc;
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
   endtask

   task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
      int c0;
      send(1'b1, a, d, '0, c0);
      @(negedge clk);
      check("wr_c1_strobes", {bus.mem_write, bus.mem_read, bus.wr_done}, 3'b100);
      check("wr_c1_addr", bus.mem_addr, a);
      check("wr_c1_data", bus.mem_wdata, d);
      @(negedge clk);
      check("wr_c2_done", {bus.mem_write, bus.wr_done, bus.req_ready}, 3'b011);
      shadow[a] = d;
   endtask

   task automatic do_read(input logic [AW-1:0] a, input logic [AW-1:0] len, output logic [DW-1:0] first);
      int c0;
      int n = 0;
      int busy_bad = 0;
      int wr_seen = 0;
      q_data.delete();
      q_cyc.delete();
      q_addr.delete();
      send(1'b0, a, '0, len, c0);
      while (q_data.size() < len + 1 && n < 100) begin
         @(negedge clk);
         #1;
         n++;
         if (cyc < c0 + len + 3 && !bus.busy) busy_bad++;
         if (bus.mem_write) wr_seen++;
      end
      check("rd_beats", q_data.size(), len + 1);
      check("rd_mem_read_cycles", q_addr.size(), len + 1);
      for (int i = 0; i < q_data.size(); i++) begin
         check("rd_data", q_data[i], shadow[AW'(a + i)]);
         check("rd_cycle", q_cyc[i], c0 + 3 + i);
      end
      for (int i = 0; i < q_addr.size(); i++) check("rd_mem_addr", q_addr[i], AW'(a + i));
      check("rd_busy", busy_bad, 0);
      check("rd_no_write", wr_seen, 0);
      first = (q_data.size() > 0) ? q_data[0] : 'x;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t          tbl [8];
      logic [DW-1:0] first;
      int            c0;
      int            n;

      tbl[0] = '{1'b1, 5'd5,  8'hA5, 5'd0, 8'h00};
      tbl[1] = '{1'b0, 5'd5,  8'h00, 5'd0, 8'hA5};
      tbl[2] = '{1'b1, 5'd10, 8'h3C, 5'd0, 8'h00};
      tbl[3] = '{1'b1, 5'd11, 8'hC3, 5'd0, 8'h00};
      tbl[4] = '{1'b0, 5'd10, 8'h00, 5'd1, 8'h3C};
      tbl[5] = '{1'b1, 5'd5,  8'h5A, 5'd0, 8'h00};
      tbl[6] = '{1'b0, 5'd5,  8'h00, 5'd0, 8'h5A};
      tbl[7] = '{1'b0, 5'd11, 8'h00, 5'd0, 8'hC3};

      bus.req_valid = 1'b1;
      bus.req_we    = 1'b0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
      bus.req_len   = '0;
      repeat (3) begin
         @(negedge clk);
         check("reset_outputs", {bus.req_ready, bus.mem_read, bus.mem_write, bus.rsp_valid, bus.wr_done}, 5'b0);
      end
      bus.req_valid = 1'b0;
      rst_n = 1'b1;
      #1 check("reset_release_ready", bus.req_ready, 1);

      for (int i = 0; i < 8; i++) begin
         if (tbl[i].we) do_write(tbl[i].addr, tbl[i].data);
         else begin
            do_read(tbl[i].addr, tbl[i].len, first);
            check("tbl_first_beat", first, tbl[i].exp0);
         end
      end

      do_write(5'd30, 8'h11);
      do_write(5'd31, 8'h22);
      do_write(5'd0,  8'h33);
      do_write(5'd1,  8'h44);
      do_read(5'd30, 5'd3, first);
      check("wrap_first", first, 8'h11);
      check("wrap_last", q_data.size() == 4 ? q_data[3] : 8'hxx, 8'h44);
      check("wrap_addr3", q_addr.size() == 4 ? q_addr[2] : 5'hxx, 5'd0);

      for (int a = 0; a < 32; a++) do_write(AW'(a), ~DW'(a));
      do_read(5'd0, 5'd31, first);
      check("full_first", first, 8'hFF);
      check("full_last", q_data.size() == 32 ? q_data[31] : 8'hxx, 8'hE0);

      q_data.delete();
      send(1'b0, 5'd12, '0, 5'd1, c0);
      bus.req_we    = 1'b1;
      bus.req_addr  = 5'd7;
      bus.req_wdata = 8'h5A;
      bus.req_valid = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         #1;
         n++;
      end while (!bus.req_ready && n < 50);
      check("b2b_accept_cycle", cyc, c0 + 4);
      check("b2b_last_rsp", bus.rsp_valid, 1);
      check("b2b_beats", q_data.size(), 2);
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      @(negedge clk);
      check("b2b_write", {bus.mem_write, bus.mem_read}, 2'b10);
      check("b2b_write_addr", bus.mem_addr, 5'd7);
      @(negedge clk);
      check("b2b_wr_done", bus.wr_done, 1);
      shadow[7] = 8'h5A;
      do_read(5'd7, 5'd0, first);
      check("b2b_readback", first, 8'h5A);

      q_data.delete();
      send(1'b0, 5'd0, '0, 5'd7, c0);
      n = 0;
      while (q_data.size() < 2 && n < 50) begin
         @(negedge clk);
         #1;
         n++;
      end
      check("midrst_two_beats", q_data.size(), 2);
      #1 rst_n = 1'b0;
      #1 check("midrst_outputs", {bus.req_ready, bus.mem_read, bus.mem_write, bus.rsp_valid, bus.wr_done, bus.busy}, 6'b0);
      check("midrst_rdata", bus.rsp_rdata, 8'h00);
      @(negedge clk);
      #1 rst_n = 1'b1;
      q_data.delete();
      repeat (15) @(negedge clk);
      #1 check("midrst_no_rsp", q_data.size(), 0);
      do_read(5'd3, 5'd2, first);
      check("midrst_recover", first, 8'hFC);

      check("no_overlap", overlaps, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/mem_master.md
Name: mem_master

Overview:
- Initiator-side controller for the 32x8 synchronous memory model.
- Accepts single-beat write requests and incrementing read bursts on a valid/ready request port.
- Drives the memory's read/write/addr/data_in pins with correct one-hot timing and captures data_out after the memory's registered read latency.
- Returns read data on a response strobe. Sits between a bus-side agent or sequencer and the memory.

Parameters:
- ADDR_W, 5, memory address width (depth 2**ADDR_W = 32).
- DATA_W, 8, data width.
- RD_LAT, 1, edges from the mem_read cycle until mem_rdata is valid. The memory model has latency 1; RD_LAT must be >= 1.

Ports:
- clk  in  1  rising-edge clock, shared with the memory.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_we  in  1  1 = write, 0 = read burst.
- req_addr  in  ADDR_W  start address.
- req_wdata  in  DATA_W  write data (write requests only).
- req_len  in  ADDR_W  read burst beats minus 1 (0 gives 1 beat, 31 gives 32 beats); ignored for writes.
- rsp_valid  out  1  one-cycle strobe per read beat; no backpressure.
- rsp_rdata  out  DATA_W  read data, valid while rsp_valid = 1.
- wr_done  out  1  one-cycle pulse when a write has been committed.
- busy  out  1  high whenever state != IDLE.
- mem_read  out  1  to memory read.
- mem_write  out  1  to memory write.
- mem_addr  out  ADDR_W  to memory addr.
- mem_wdata  out  DATA_W  to memory data_in.
- mem_rdata  in  DATA_W  from memory data_out.

Behaviour:
- One clock; reset is asynchronous and active-low. While rst_n = 0:
  - state = IDLE;
  - all outputs = 0, including req_ready, which stays 0 while reset is asserted;
  - the capture pipeline is flushed.
- Reset asserted mid-burst aborts the burst; no rsp_valid or wr_done follows.
- All mem_* outputs, rsp_valid, rsp_rdata and wr_done are registered. req_ready = (state == IDLE) && rst_n.
- Invariant: mem_read and mem_write are never 1 in the same cycle. The memory ignores both if they are.
- Handshake: a request is accepted at the rising edge where req_valid && req_ready. The accept cycle is C0. req_* are sampled only at that edge.
- State machine: IDLE, WRITE, READ, DRAIN.
- IDLE -> WRITE on accept with req_we = 1.
  - In C1: mem_write = 1, mem_addr = req_addr, mem_wdata = req_wdata.
  - The memory commits at the end of C1.
  - In C2: wr_done = 1, state = IDLE, req_ready = 1.
  - Write throughput: one write per 2 cycles.
- IDLE -> READ on accept with req_we = 0. Load beat counter = req_len and current address = req_addr.
  - In READ: mem_read = 1, mem_addr = current address.
  - At each edge: address += 1 modulo 2**ADDR_W (31 wraps to 0); counter -= 1.
  - When counter == 0 at an edge, go to DRAIN with mem_read = 0.
  - mem_read is high for cycles C1 .. C(req_len+1).
- Capture pipeline: a RD_LAT+1 deep valid shift register tags each mem_read cycle.
  - The tagged mem_rdata is registered into rsp_rdata with rsp_valid = 1.
  - With RD_LAT = 1: rsp_valid is high in C3 .. C(req_len+3), one beat per cycle, in address order.
- DRAIN -> IDLE on the edge that captures the last beat. The last rsp_valid and req_ready = 1 therefore coincide. A new request can be accepted in that same cycle.
- mem_wdata holds its last value when mem_write = 0. mem_addr holds its last value when the memory is idle.
- req_valid while busy: ignored (req_ready = 0). The requester must hold req_* stable until accepted.

Test Plan:
- Reset: rst_n = 0 for 3 cycles with req_valid = 1 -> req_ready, mem_read, mem_write, rsp_valid and wr_done all stay 0. After release, req_ready = 1 in the first cycle.
- Single write then read: write addr 5, data 0xA5 -> mem_write = 1 for exactly 1 cycle with mem_addr = 5, and wr_done pulses the next cycle. Then read addr 5, len 0 -> one rsp_valid carrying 0xA5, 3 cycles after accept.
- Burst with wrap: preload addr 30 = 0x11, 31 = 0x22, 0 = 0x33, 1 = 0x44. Read addr 30, len 3 -> mem_addr sequence 30, 31, 0, 1; 4 consecutive rsp_valid beats carrying 0x11, 0x22, 0x33, 0x44.
- Full 32-beat burst (addr 0, len 31) after writing data = ~addr at every location -> 32 contiguous beats 0xFF .. 0xE0. busy = 1 throughout, and mem_write is never 1.
- Back-to-back: a write request is held valid while a len = 1 read drains -> the write is accepted in the cycle of the last rsp_valid, with no overlap of mem_read and mem_write.
- Reset mid-burst: rst_n pulsed low during beat 2 of an 8-beat read -> outputs clear immediately, no further rsp_valid, and the next request is served normally.
